// File: rtl/mssd_pkg.sv
// Shared types and widths for the MSSD transmit scheduler.
// Frame layout: start bit, destination, byte count, then MSB-first payload bytes.
package mssd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DEST,
    ST_COUNT,
    ST_DATA,
    ST_GAP
  } mssd_tx_state_t;

  localparam int   DEST_W    = 2;
  localparam int   CNT_W     = 4;
  localparam int   BYTE_W    = 8;
  localparam logic LINE_IDLE = 1'b1;

  // Extract channel idx's 4-bit length from the packed per-channel length bus.
  function automatic logic [CNT_W-1:0] chan_len(input logic [4*CNT_W-1:0] lens,
                                                input logic [DEST_W-1:0]  idx);
    return lens[{idx, 2'b00} +: CNT_W];
  endfunction

endpackage

// File: rtl/mssd_tx_scheduler_if.sv
// Channel-side bundle of the scheduler: requests, lengths and byte supply in; grant, pop strobe and line out.
// master = requesting channels / byte sources, slave = the scheduler.
interface mssd_tx_scheduler_if;
  import mssd_pkg::*;

  logic [3:0]         req;
  logic [4*CNT_W-1:0] len;
  logic [BYTE_W-1:0]  data_in;
  logic [3:0]         grant;
  logic               byte_rd;
  logic               serOut;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output req, len, data_in,
    input  grant, byte_rd, serOut, busy, done, err
  );

  modport slave (
    input  req, len, data_in,
    output grant, byte_rd, serOut, busy, done, err
  );

endinterface

// File: rtl/mssd_rr_arbiter.sv
// Combinational rotate-priority arbiter over four requesters; search starts one past i_ptr.
// Zero latency; no backpressure, o_vld simply reflects any enabled request.
module mssd_rr_arbiter
  import mssd_pkg::*;
(
  input  logic [3:0]        i_req,
  input  logic [DEST_W-1:0] i_ptr,
  input  logic              i_en,
  output logic              o_vld,
  output logic [3:0]        o_gnt,
  output logic [DEST_W-1:0] o_idx
);

  logic [DEST_W-1:0] w_cand;

  always_comb begin
    o_vld  = 1'b0;
    o_gnt  = '0;
    o_idx  = '0;
    w_cand = '0;
    // i = 4 wraps back to i_ptr itself, so the last winner has lowest priority.
    for (int i = 1; i <= 4; i++) begin
      w_cand = i_ptr + DEST_W'(i);
      if (i_en && !o_vld && i_req[w_cand]) begin
        o_vld         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/mssd_tx_scheduler.sv
// Round-robin MSSD transmit scheduler: start bit 1 cycle after a winning request, frame 7+8L cycles, GAP idle cycles.
// No stall: the granted source must present data_in combinationally whenever byte_rd is high.
module mssd_tx_scheduler
  import mssd_pkg::*;
#(
  parameter int GAP = 2
) (
  input  logic               clk,
  input  logic               reset,
  mssd_tx_scheduler_if.slave io_bus
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

  mssd_tx_state_t    r_state, w_state_nxt;
  logic [DEST_W-1:0] r_ptr, w_ptr_nxt;
  logic [DEST_W-1:0] r_dest, w_dest_nxt;
  logic [CNT_W-1:0]  r_len, w_len_nxt;
  logic [CNT_W-1:0]  r_bcnt, w_bcnt_nxt;
  logic [CNT_W-1:0]  r_bytes, w_bytes_nxt;
  logic [BYTE_W-1:0] r_shreg, w_shreg_nxt;
  logic              r_ser, w_ser_nxt;
  logic [3:0]        r_grant, w_grant_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_err, w_err_nxt;
  logic              w_byte_rd;
  logic              w_done;

  logic              w_arb_vld;
  logic [3:0]        w_arb_gnt;
  logic [DEST_W-1:0] w_arb_idx;
  logic [CNT_W-1:0]  w_arb_len;
  logic [1:0]        w_len_sel;

  mssd_rr_arbiter u_arb (
    .i_req (io_bus.req),
    .i_ptr (r_ptr),
    .i_en  (r_state == ST_IDLE),
    .o_vld (w_arb_vld),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_arb_len = chan_len(io_bus.len, w_arb_idx);
  assign w_len_sel = 2'd2 - r_bcnt[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd3;
      r_dest  <= '0;
      r_len   <= '0;
      r_bcnt  <= '0;
      r_bytes <= '0;
      r_shreg <= '0;
      r_ser   <= LINE_IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_dest  <= w_dest_nxt;
      r_len   <= w_len_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_bytes <= w_bytes_nxt;
      r_shreg <= w_shreg_nxt;
      r_ser   <= w_ser_nxt;
      r_grant <= w_grant_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // w_ser_nxt is the line value for the following cycle, so every field bit is registered.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_dest_nxt  = r_dest;
    w_len_nxt   = r_len;
    w_bcnt_nxt  = r_bcnt;
    w_bytes_nxt = r_bytes;
    w_shreg_nxt = r_shreg;
    w_ser_nxt   = r_ser;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    w_err_nxt   = 1'b0;
    w_byte_rd   = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_ser_nxt = LINE_IDLE;
        if (w_arb_vld) begin
          w_ptr_nxt = w_arb_idx;
          if (w_arb_len == '0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_START;
            w_grant_nxt = w_arb_gnt;
            w_busy_nxt  = 1'b1;
            w_ser_nxt   = 1'b0;
            w_len_nxt   = w_arb_len;
            w_dest_nxt  = w_arb_idx;
          end
        end
      end

      ST_START: begin
        w_state_nxt = ST_DEST;
        w_ser_nxt   = r_dest[1];
        w_bcnt_nxt  = '0;
      end

      ST_DEST: begin
        if (r_bcnt == '0) begin
          w_ser_nxt  = r_dest[0];
          w_bcnt_nxt = 4'd1;
        end else begin
          w_state_nxt = ST_COUNT;
          w_ser_nxt   = r_len[3];
          w_bcnt_nxt  = '0;
        end
      end

      ST_COUNT: begin
        if (r_bcnt == 4'd3) begin
          w_byte_rd   = 1'b1;
          w_state_nxt = ST_DATA;
          w_ser_nxt   = io_bus.data_in[7];
          w_shreg_nxt = {io_bus.data_in[6:0], 1'b0};
          w_bcnt_nxt  = '0;
          w_bytes_nxt = r_len;
        end else begin
          w_ser_nxt  = r_len[w_len_sel];
          w_bcnt_nxt = r_bcnt + 4'd1;
        end
      end

      ST_DATA: begin
        if (r_bcnt == 4'd7) begin
          w_bcnt_nxt = '0;
          if (r_bytes == 4'd1) begin
            w_done      = 1'b1;
            w_state_nxt = ST_GAP;
            w_ser_nxt   = LINE_IDLE;
            w_grant_nxt = '0;
          end else begin
            w_byte_rd   = 1'b1;
            w_ser_nxt   = io_bus.data_in[7];
            w_shreg_nxt = {io_bus.data_in[6:0], 1'b0};
            w_bytes_nxt = r_bytes - 4'd1;
          end
        end else begin
          w_ser_nxt   = r_shreg[7];
          w_shreg_nxt = {r_shreg[6:0], 1'b0};
          w_bcnt_nxt  = r_bcnt + 4'd1;
        end
      end

      ST_GAP: begin
        w_ser_nxt = LINE_IDLE;
        if (r_bcnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_bcnt_nxt  = '0;
        end else begin
          w_bcnt_nxt = r_bcnt + 4'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign io_bus.grant   = r_grant;
  assign io_bus.byte_rd = w_byte_rd;
  assign io_bus.serOut  = r_ser;
  assign io_bus.busy    = r_busy;
  assign io_bus.done    = w_done;
  assign io_bus.err     = r_err;

endmodule

// File: tb/tb_mssd_tx_scheduler.sv
// Randomized bench for mssd_tx_scheduler: a frame-level model predicts every output cycle by cycle.
module tb_mssd_tx_scheduler;

  localparam int TB_GAP = 2;
  localparam int N_CYC  = 3000;

  typedef struct {
    logic       ser;
    logic [3:0] gnt;
    logic       busy;
    logic       done;
    logic       rd;
    logic       err;
    logic       arb;
    int         dbit;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   m_ptr;
  int   cyc;
  exp_t q[$];
  logic [7:0] bq[$];
  exp_t cur;

  mssd_tx_scheduler_if bus ();

  mssd_tx_scheduler #(.GAP(TB_GAP)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.ser = 1'b1; e.gnt = 4'b0; e.busy = 1'b0; e.done = 1'b0;
    e.rd = 1'b0; e.err = 1'b0; e.arb = 1'b1; e.dbit = -1;
    return e;
  endfunction

  task automatic check_outputs(input string pfx, input exp_t e);
    chk({pfx, ".serOut"},  bus.serOut,  e.ser);
    chk({pfx, ".grant"},   bus.grant,   e.gnt);
    chk({pfx, ".busy"},    bus.busy,    e.busy);
    chk({pfx, ".done"},    bus.done,    e.done);
    chk({pfx, ".byte_rd"}, bus.byte_rd, e.rd);
    chk({pfx, ".err"},     bus.err,     e.err);
  endtask

  // Round-robin pick, then expand the whole frame (plus gap) into per-cycle expectations.
  task automatic model_arb(input logic [3:0] rq, input logic [15:0] ln);
    int   win;
    int   L;
    int   total;
    logic bits[$];
    logic [7:0] b;
    exp_t e;
    win = -1;
    for (int i = 1; i <= 4; i++)
      if (win < 0 && rq[(m_ptr + i) % 4]) win = (m_ptr + i) % 4;
    if (win < 0) return;
    m_ptr = win;
    L = int'((ln >> (4 * win)) & 16'hF);
    if (L == 0) begin
      e = idle_exp();
      e.err = 1'b1;
      q.push_back(e);
      return;
    end
    bits.push_back(1'b0);
    bits.push_back(win[1]);
    bits.push_back(win[0]);
    for (int k = 3; k >= 0; k--) bits.push_back(L[k]);
    for (int n = 0; n < L; n++) begin
      b = 8'($urandom);
      bq.push_back(b);
      for (int k = 7; k >= 0; k--) bits.push_back(b[k]);
    end
    total = 7 + 8 * L;
    for (int t = 1; t <= total; t++) begin
      e.ser  = bits[t-1];
      e.gnt  = 4'(1 << win);
      e.busy = 1'b1;
      e.done = (t == total);
      e.rd   = (t >= 7) && (t < total) && ((t - 7) % 8 == 0);
      e.err  = 1'b0;
      e.arb  = 1'b0;
      e.dbit = (t >= 8) ? t - 8 : -1;
      q.push_back(e);
    end
    for (int g = 0; g < TB_GAP; g++) begin
      e = idle_exp();
      e.busy = 1'b1;
      e.arb  = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic step(input logic force_ch1);
    logic [3:0]  rq;
    logic [15:0] ln;
    @(negedge clk);
    cyc++;
    if (q.size() > 0) cur = q.pop_front();
    else cur = idle_exp();
    check_outputs("cyc", cur);
    if (cur.rd) bus.data_in = (bq.size() > 0) ? bq.pop_front() : 8'h00;
    else bus.data_in = 8'($urandom);
    if (force_ch1) begin
      rq = 4'b0010;
      ln = 16'h0010;
    end else if (cyc < 150) begin
      rq = 4'hF;
      ln = 16'h1111;
    end else if (cyc < 160) begin
      rq = 4'b0100;
      ln = 16'($urandom) & 16'hF0FF;
    end else if (cyc < 300) begin
      rq = 4'b0110;
      ln = (16'($urandom) & 16'hF00F) | 16'h0010;
    end else begin
      rq = 4'($urandom);
      for (int c = 0; c < 4; c++) ln[4*c +: 4] = 4'($urandom_range(0, 5));
    end
    bus.req = rq;
    bus.len = ln;
    if (cur.arb) model_arb(rq, ln);
  endtask

  initial begin
    logic did_rst;
    logic fch;
    reset       = 1'b1;
    bus.req     = 4'b0;
    bus.len     = 16'b0;
    bus.data_in = 8'b0;
    m_ptr       = 3;
    cyc         = 0;
    did_rst     = 1'b0;
    fch         = 1'b0;
    #1 reset = 1'b0;
    #1 check_outputs("rst", idle_exp());
    bus.req = 4'hF;
    bus.len = 16'h1111;
    repeat (2) @(posedge clk);
    #1 check_outputs("rst_hold", idle_exp());
    bus.req = 4'b0;
    #1 reset = 1'b1;

    while (cyc < N_CYC) begin
      step(fch);
      fch = 1'b0;
      if (!did_rst && cyc > 400 && cur.dbit == 3) begin
        did_rst = 1'b1;
        #2 reset = 1'b0;
        #1 check_outputs("midrst", idle_exp());
        q.delete();
        bq.delete();
        m_ptr = 3;
        repeat (2) @(posedge clk);
        #1 check_outputs("midrst_hold", idle_exp());
        #1 reset = 1'b1;
        fch = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
